riscv_wb_stage: RTL and testbench
=================================

RISCV_WB_STAGE -- requirements
Module: riscv_wb_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width; only 32 is supported.
REQ-002 Parameter LOAD_TIMEOUT, default 16, meaning the maximum number of cycles spent waiting for load data (watchdog only).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk_i is the clock, rst_ni is the reset.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mem_insn_i  in  instruction_t  memory-stage instruction (instr, bubble, dbg)
- mem_r_i  in  XLEN  memory-stage result (ALU, CSR or link value)
- mem_adr_lsb_i  in  2  load byte address bits [1:0]
- dmem_ack_i  in  1  load data valid
- dmem_err_i  in  1  load bus error
- dmem_q_i  in  XLEN  raw load data word
- wb_flush_i  in  1  kill the instruction held in or entering write-back
- wb_stall_o  out  1  stall upstream stages
- wb_insn_o  out  instruction_t  write-back instruction
- wb_we_o  out  1  register-file write enable
- wb_dst_o  out  5  destination register (instr[11:7])
- wb_r_o  out  XLEN  write-back result
- wb_err_o  out  1  one-cycle load-error/timeout pulse

Function
REQ-005 A load SHALL be defined as mem_insn_i.bubble=0 and opcode instr[6:0]=7'b0000011.
REQ-006 The FSM SHALL have exactly two states, IDLE and WAIT.
- IDLE->WAIT on a load with dmem_ack_i=0 and dmem_err_i=0.
- WAIT->IDLE on dmem_ack_i, dmem_err_i or wb_flush_i.
- All other cases hold the current state.
REQ-007 wb_stall_o SHALL be combinational and equal 1 exactly when (IDLE and load without ack/err) or (WAIT without ack/err/flush).
REQ-008 Load alignment SHALL use sh=dmem_q_i>>(8*mem_adr_lsb_i), with funct3 = instr[14:12].
- LB (000) sign-extends sh[7:0].
- LH (001) sign-extends sh[15:0].
- LW (010) passes sh unchanged.
- LBU (100) zero-extends sh[7:0].
- LHU (101) zero-extends sh[15:0].
- Other funct3 values yield 0.
REQ-009 On each clk_i edge with wb_stall_o=0, the output registers SHALL load as follows.
- wb_insn_o <= mem_insn_i.
- wb_dst_o <= instr[11:7].
- wb_r_o <= aligned load data for loads, mem_r_i otherwise.
REQ-010 wb_we_o SHALL be registered with wb_insn_o and equal 1 only when all of the following hold: bubble=0, no flush, no error, rd!=0, and opcode is one of LOAD, OP_IMM, OP, LUI, AUIPC, JAL, JALR or SYSTEM.
REQ-011 While wb_stall_o=1, wb_insn_o.bubble SHALL be 1 and wb_we_o 0; wb_r_o and wb_dst_o SHALL hold their values.
REQ-012 Write-back latency SHALL be 1 cycle from memory-stage presentation, or 1 cycle after dmem_ack_i for a waiting load.
REQ-013 wb_flush_i SHALL take priority over ack and err: the registered bubble is 1, wb_we_o is 0, the FSM goes to IDLE, and no error pulse is raised.
REQ-014 dmem_err_i on an unflushed load SHALL produce a wb_err_o pulse registered with that instruction, wb_we_o=0, and the FSM goes to IDLE.
REQ-015 dmem_ack_i and dmem_err_i SHALL be ignored in IDLE when no load is presented; if both are asserted together, err wins.
REQ-016 wb_insn_o.dbg SHALL propagate unmodified with the instruction.

Reset
REQ-017 While rst_ni=0, the block SHALL asynchronously set the following values.
- FSM = IDLE.
- wb_insn_o.instr = INSTR_NOP, wb_insn_o.bubble = 1, wb_insn_o.dbg = 0.
- wb_we_o = 0, wb_dst_o = 0, wb_r_o = 0, wb_err_o = 0.
- Watchdog counter = 0.
REQ-018 A reset asserted mid-WAIT SHALL abandon the load and leave no pending state after release.

Configuration
REQ-019 Macro RV_WB_LOAD_WATCHDOG_EN, when defined, SHALL enable the load watchdog.
- Counter clears on entering WAIT and increments each WAIT cycle.
- On reaching LOAD_TIMEOUT-1 without ack/err/flush, the block treats the cycle as dmem_err_i=1 (REQ-014).
REQ-020 Without RV_WB_LOAD_WATCHDOG_EN, no counter SHALL exist and WAIT SHALL persist indefinitely.

Verification
REQ-021 Reset, then ADDI x5 (rd=5) with mem_r_i=0x1234 -> next cycle wb_we_o=1, wb_dst_o=5, wb_r_o=0x00001234.
REQ-022 LB, lsb=2'b11, dmem_q_i=0x80AA5500, ack in the same cycle -> wb_r_o=0xFFFFFF80; LBU with identical stimulus -> 0x00000080.
REQ-023 LW, ack delayed 3 cycles -> wb_stall_o=1 for 3 cycles with wb_we_o=0; the cycle after ack -> wb_we_o=1, wb_r_o=dmem_q_i, FSM IDLE.
REQ-024 Load in WAIT with wb_flush_i and dmem_ack_i in the same cycle -> wb_we_o=0, bubble=1, wb_err_o=0, stall released.
REQ-025 With RV_WB_LOAD_WATCHDOG_EN and LOAD_TIMEOUT=4, a load with no ack -> wb_err_o pulses once after 4 WAIT cycles, wb_we_o=0, FSM IDLE.
REQ-026 rst_ni asserted during WAIT -> all outputs at their REQ-017 values immediately; after release, ADDI x0 -> wb_we_o=0.

Source files
------------

// File: rtl/riscv_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wb_stage
//  Purpose  : RISC-V write-back stage. Registers the memory-stage result,
//             aligns and sign/zero-extends load data, and stalls the pipeline
//             while a load waits for its data.
//  Ports    : clk_i, rst_ni (async, active low)
//             mem_insn_i / mem_r_i / mem_adr_lsb_i : memory-stage instruction,
//                                                   result, load byte offset
//             dmem_ack_i / dmem_err_i / dmem_q_i   : load response
//             wb_flush_i                           : kill write-back instr
//             wb_stall_o                           : stall upstream stages
//             wb_insn_o / wb_we_o / wb_dst_o / wb_r_o / wb_err_o : write-back
//  Options  : define RV_WB_LOAD_WATCHDOG_EN to enable the load watchdog, which
//             turns a load waiting LOAD_TIMEOUT cycles into a load error.
//  Revision : 1.0 - initial release
// ============================================================================

package riscv_wb_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic        bubble;
        logic        dbg;
    } instruction_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

module riscv_wb_stage
    import riscv_wb_pkg::*;
#(
    parameter int unsigned XLEN         = 32,   // only 32 is supported
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  instruction_t     mem_insn_i,
    input  logic [XLEN-1:0]  mem_r_i,
    input  logic [1:0]       mem_adr_lsb_i,
    input  logic             dmem_ack_i,
    input  logic             dmem_err_i,
    input  logic [XLEN-1:0]  dmem_q_i,
    input  logic             wb_flush_i,
    output logic             wb_stall_o,
    output instruction_t     wb_insn_o,
    output logic             wb_we_o,
    output logic [4:0]       wb_dst_o,
    output logic [XLEN-1:0]  wb_r_o,
    output logic             wb_err_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    instruction_t    wb_insn_q;
    logic            wb_we_q;
    logic [4:0]      wb_dst_q;
    logic [XLEN-1:0] wb_r_q;
    logic            wb_err_q;

    // Instruction field decode
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic            w_load;
    logic            w_writes_rd;
    logic            w_timeout;
    logic            w_err_eff;
    logic            w_stall;
    logic            w_we_d;
    logic            w_err_d;
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_load_data;
    logic            w_unused_bits;

    assign w_opcode      = mem_insn_i.instr[6:0];
    assign w_rd          = mem_insn_i.instr[11:7];
    assign w_funct3      = mem_insn_i.instr[14:12];
    assign w_unused_bits = ^mem_insn_i.instr[31:15];

    assign w_load = !mem_insn_i.bubble && (w_opcode == OPC_LOAD);

    always_comb begin
        w_writes_rd = 1'b0;
        case (w_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM: w_writes_rd = 1'b1;
            default:                                  w_writes_rd = 1'b0;
        endcase
    end

`ifdef RV_WB_LOAD_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(LOAD_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && state_d == S_WAIT) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the watchdog a waiting load never times out.
    localparam int unsigned C_UNUSED_TIMEOUT = LOAD_TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    // A timeout behaves exactly like a bus error on the waiting load.
    assign w_err_eff = dmem_err_i || w_timeout;

    // Next state and stall
    always_comb begin
        state_d = state_q;
        w_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_load && !dmem_ack_i && !dmem_err_i) begin
                    state_d = S_WAIT;
                    w_stall = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ack_i || w_err_eff || wb_flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load alignment: shift the addressed byte/halfword down to bit 0.
    assign w_sh = dmem_q_i >> {mem_adr_lsb_i, 3'b000};

    always_comb begin
        w_load_data = '0;
        case (w_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_sh[7]}},   w_sh[7:0]};
            3'b001:  w_load_data = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
            3'b010:  w_load_data = w_sh;
            3'b100:  w_load_data = {{(XLEN-8){1'b0}},      w_sh[7:0]};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}},     w_sh[15:0]};
            default: w_load_data = '0;
        endcase
    end

    // Flush outranks error: a flushed load neither writes nor reports.
    assign w_err_d = w_load && w_err_eff && !wb_flush_i;
    assign w_we_d  = !mem_insn_i.bubble && !wb_flush_i && !(w_load && w_err_eff)
                     && (w_rd != 5'd0) && w_writes_rd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_IDLE;
            wb_insn_q.instr  <= INSTR_NOP;
            wb_insn_q.bubble <= 1'b1;
            wb_insn_q.dbg    <= 1'b0;
            wb_we_q          <= 1'b0;
            wb_dst_q         <= 5'd0;
            wb_r_q           <= '0;
            wb_err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_stall) begin
                // Insert a bubble; result and destination hold.
                wb_insn_q.bubble <= 1'b1;
                wb_we_q          <= 1'b0;
                wb_err_q         <= 1'b0;
            end else begin
                wb_insn_q.instr  <= mem_insn_i.instr;
                wb_insn_q.bubble <= mem_insn_i.bubble || wb_flush_i;
                wb_insn_q.dbg    <= mem_insn_i.dbg;
                wb_we_q          <= w_we_d;
                wb_dst_q         <= w_rd;
                wb_r_q           <= w_load ? w_load_data : mem_r_i;
                wb_err_q         <= w_err_d;
            end
        end
    end

    assign wb_stall_o = w_stall;
    assign wb_insn_o  = wb_insn_q;
    assign wb_we_o    = wb_we_q;
    assign wb_dst_o   = wb_dst_q;
    assign wb_r_o     = wb_r_q;
    assign wb_err_o   = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_wb_stage
//  Purpose  : Self-checking bench for riscv_wb_stage. Directed stimulus pushes
//             hand-computed expectations into a scoreboard queue; a monitor
//             pops and compares whenever write-back presents an instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_wb_stage;
    import riscv_wb_pkg::*;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] r;
        logic        err;
        logic        dbg;
    } exp_t;

    logic         clk;
    logic         rst_n;
    instruction_t mem_insn;
    logic [31:0]  mem_r;
    logic [1:0]   lsb;
    logic         ack, err, flush;
    logic [31:0]  q;
    logic         stall;
    instruction_t wb_insn;
    logic         wb_we;
    logic [4:0]   wb_dst;
    logic [31:0]  wb_r;
    logic         wb_err;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    riscv_wb_stage #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_insn_i   (mem_insn),
        .mem_r_i      (mem_r),
        .mem_adr_lsb_i(lsb),
        .dmem_ack_i   (ack),
        .dmem_err_i   (err),
        .dmem_q_i     (q),
        .wb_flush_i   (flush),
        .wb_stall_o   (stall),
        .wb_insn_o    (wb_insn),
        .wb_we_o      (wb_we),
        .wb_dst_o     (wb_dst),
        .wb_r_o       (wb_r),
        .wb_err_o     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        mem_insn = '{instr: C_NOP, bubble: 1'b1, dbg: 1'b0};
        mem_r = 32'h0; lsb = 2'd0; ack = 1'b0; err = 1'b0; flush = 1'b0; q = 32'h0;
    endtask

    task automatic present(input logic [31:0] instr, input logic dbg, input logic [31:0] r,
                           input logic [1:0] a, input logic [31:0] d,
                           input logic k, input logic e, input logic f);
        mem_insn = '{instr: instr, bubble: 1'b0, dbg: dbg};
        mem_r = r; lsb = a; q = d; ack = k; err = e; flush = f;
    endtask

    task automatic expect_wb(input logic [31:0] instr, input logic we, input logic [4:0] dst,
                             input logic [31:0] r, input logic e, input logic dbg);
        exp_t x;
        x.instr = instr; x.we = we; x.dst = dst; x.r = r; x.err = e; x.dbg = dbg;
        sb.push_back(x);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction that must not stall, then advance.
    task automatic issue(input string name);
        @(negedge clk);
        chk(name, {31'd0, stall}, 32'd0);
        next_cycle();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_instr"},  wb_insn.instr, C_NOP);
        chk({tag, "_bubble"}, {31'd0, wb_insn.bubble}, 32'd1);
        chk({tag, "_dbg"},    {31'd0, wb_insn.dbg}, 32'd0);
        chk({tag, "_we"},     {31'd0, wb_we}, 32'd0);
        chk({tag, "_dst"},    {27'd0, wb_dst}, 32'd0);
        chk({tag, "_r"},      wb_r, 32'd0);
        chk({tag, "_err"},    {31'd0, wb_err}, 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (!wb_insn.bubble || wb_err)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got instr %h we %0b dst %0d r %h err %0b, expected nothing",
                         wb_insn.instr, wb_we, wb_dst, wb_r, wb_err);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (wb_insn.instr !== x.instr || wb_we !== x.we || wb_dst !== x.dst ||
                    wb_r !== x.r || wb_err !== x.err || wb_insn.dbg !== x.dbg) begin
                    n_fail++;
                    $display("FAIL sb_%h: got we %0b dst %0d r %h err %0b dbg %0b, expected we %0b dst %0d r %h err %0b dbg %0b",
                             x.instr, wb_we, wb_dst, wb_r, wb_err, wb_insn.dbg,
                             x.we, x.dst, x.r, x.err, x.dbg);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] i_addi5, i_lb, i_lbu, i_lh, i_lhu, i_lw, i_sw, i_addi0;
        logic [31:0] i_lwd, i_lwf, i_lwe, i_lwb, i_lwt, i_lwr, i_addi3;
        i_addi5 = itype(12'h034, 5'd0, 3'b000, 5'd5,  7'b0010011);
        i_lb    = itype(12'h000, 5'd1, 3'b000, 5'd6,  7'b0000011);
        i_lbu   = itype(12'h000, 5'd1, 3'b100, 5'd7,  7'b0000011);
        i_lh    = itype(12'h000, 5'd1, 3'b001, 5'd8,  7'b0000011);
        i_lhu   = itype(12'h000, 5'd1, 3'b101, 5'd9,  7'b0000011);
        i_lw    = itype(12'h000, 5'd1, 3'b010, 5'd10, 7'b0000011);
        i_sw    = itype(12'h002, 5'd1, 3'b010, 5'd9,  7'b0100011);
        i_addi0 = itype(12'h001, 5'd0, 3'b000, 5'd0,  7'b0010011);
        i_lwd   = itype(12'h004, 5'd2, 3'b010, 5'd11, 7'b0000011);
        i_lwf   = itype(12'h008, 5'd2, 3'b010, 5'd12, 7'b0000011);
        i_lwe   = itype(12'h00c, 5'd2, 3'b010, 5'd13, 7'b0000011);
        i_lwb   = itype(12'h010, 5'd2, 3'b010, 5'd14, 7'b0000011);
        i_lwt   = itype(12'h014, 5'd2, 3'b010, 5'd15, 7'b0000011);
        i_lwr   = itype(12'h018, 5'd2, 3'b010, 5'd16, 7'b0000011);
        i_addi3 = itype(12'h7ff, 5'd0, 3'b000, 5'd3,  7'b0010011);

        rst_n = 1'b0;
        idle();
        repeat (2) next_cycle();
        chk_reset_values("rst");
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // ALU result write-back
        present(i_addi5, 1'b0, 32'h1234, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_wb(i_addi5, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
        issue("addi_stall");

        // Loads acknowledged in the same cycle
        present(i_lb, 1'b0, 32'h0, 2'd3, 32'h80AA_5500, 1'b1, 1'b0, 1'b0);
        expect_wb(i_lb, 1'b1, 5'd6, 32'hFFFF_FF80, 1'b0, 1'b0);
        issue("lb_stall");
        present(i_lbu, 1'b0, 32'h0, 2'd3, 32'h80AA_5500, 1'b1, 1'b0, 1'b0);
        expect_wb(i_lbu, 1'b1, 5'd7, 32'h0000_0080, 1'b0, 1'b0);
        issue("lbu_stall");
        present(i_lh, 1'b0, 32'h0, 2'd2, 32'h80AA_5500, 1'b1, 1'b0, 1'b0);
        expect_wb(i_lh, 1'b1, 5'd8, 32'hFFFF_80AA, 1'b0, 1'b0);
        issue("lh_stall");
        present(i_lhu, 1'b0, 32'h0, 2'd0, 32'h80AA_5500, 1'b1, 1'b0, 1'b0);
        expect_wb(i_lhu, 1'b1, 5'd9, 32'h0000_5500, 1'b0, 1'b0);
        issue("lhu_stall");
        present(i_lw, 1'b0, 32'h0, 2'd0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
        expect_wb(i_lw, 1'b1, 5'd10, 32'hCAFE_F00D, 1'b0, 1'b0);
        issue("lw_stall");

        // Store does not write the register file; x0 is never written
        present(i_sw, 1'b0, 32'h0000_0ABC, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_wb(i_sw, 1'b0, 5'd9, 32'h0000_0ABC, 1'b0, 1'b0);
        issue("sw_stall");
        present(i_addi0, 1'b0, 32'h0000_0001, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_wb(i_addi0, 1'b0, 5'd0, 32'h0000_0001, 1'b0, 1'b0);
        issue("addi0_stall");

        // Load with ack delayed by three cycles
        present(i_lwd, 1'b0, 32'h0, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lwd_stall0", {31'd0, stall}, 32'd1);
        next_cycle();
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("lwd_stall", {31'd0, stall}, 32'd1);
            chk("lwd_we_hold", {31'd0, wb_we}, 32'd0);
            chk("lwd_bubble", {31'd0, wb_insn.bubble}, 32'd1);
            next_cycle();
        end
        ack = 1'b1;
        expect_wb(i_lwd, 1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        chk("lwd_ack_stall", {31'd0, stall}, 32'd0);
        chk("lwd_ack_we", {31'd0, wb_we}, 32'd0);
        next_cycle();
        present(i_addi0, 1'b0, 32'h0000_0099, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_wb(i_addi0, 1'b0, 5'd0, 32'h0000_0099, 1'b0, 1'b0);
        issue("after_lwd_idle");

        // Flush and ack together while waiting
        present(i_lwf, 1'b0, 32'h0, 2'd0, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lwf_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        ack = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("lwf_release", {31'd0, stall}, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("lwf_bubble", {31'd0, wb_insn.bubble}, 32'd1);
        chk("lwf_we", {31'd0, wb_we}, 32'd0);
        chk("lwf_err", {31'd0, wb_err}, 32'd0);
        chk("lwf_idle", {31'd0, stall}, 32'd0);
        next_cycle();

        // Bus error, then ack and err together (err wins)
        present(i_lwe, 1'b0, 32'h0, 2'd0, 32'h1122_3344, 1'b0, 1'b1, 1'b0);
        expect_wb(i_lwe, 1'b0, 5'd13, 32'h1122_3344, 1'b1, 1'b0);
        issue("lwe_stall");
        present(i_lwb, 1'b0, 32'h0, 2'd0, 32'h0000_0055, 1'b1, 1'b1, 1'b0);
        expect_wb(i_lwb, 1'b0, 5'd14, 32'h0000_0055, 1'b1, 1'b0);
        issue("lwb_stall");

        // ack/err with no load are ignored
        idle();
        ack = 1'b1; err = 1'b1;
        issue("noload_stall");
        idle();
        @(negedge clk);
        chk("noload_err", {31'd0, wb_err}, 32'd0);
        chk("noload_bubble", {31'd0, wb_insn.bubble}, 32'd1);
        next_cycle();

`ifdef RV_WB_LOAD_WATCHDOG_EN
        // Watchdog: no ack ever arrives
        present(i_lwt, 1'b0, 32'h0, 2'd0, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wdog_stall", {31'd0, stall}, 32'd1);
            next_cycle();
        end
        expect_wb(i_lwt, 1'b0, 5'd15, 32'h0BAD_0BAD, 1'b1, 1'b0);
        issue("wdog_release");
        idle();
        next_cycle();
        @(negedge clk);
        chk("wdog_err_once", {31'd0, wb_err}, 32'd0);
        next_cycle();
`else
        // No watchdog: the load waits as long as needed
        present(i_lwt, 1'b0, 32'h0, 2'd0, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
        repeat (20) next_cycle();
        @(negedge clk);
        chk("long_wait_stall", {31'd0, stall}, 32'd1);
        chk("long_wait_err", {31'd0, wb_err}, 32'd0);
        next_cycle();
        ack = 1'b1;
        expect_wb(i_lwt, 1'b1, 5'd15, 32'h0BAD_0BAD, 1'b0, 1'b0);
        issue("long_wait_release");
`endif

        // Reset in the middle of a wait
        present(i_lwr, 1'b0, 32'h0, 2'd0, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        chk_reset_values("midrst");
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        present(i_addi0, 1'b0, 32'h0000_0042, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_wb(i_addi0, 1'b0, 5'd0, 32'h0000_0042, 1'b0, 1'b0);
        issue("postrst_stall");

        // Debug flag travels with the instruction
        present(i_addi3, 1'b1, 32'h0000_07FF, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_wb(i_addi3, 1'b1, 5'd3, 32'h0000_07FF, 1'b0, 1'b1);
        issue("dbg_stall");

        idle();
        repeat (3) next_cycle();
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
